// File: rtl/ann_pkg.sv
// Shared types and default sizing for the layer sequencer and the node datapath.
package ann_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MAC,
    ST_DRAIN,
    ST_LATCH,
    ST_DONE
  } state_t;

  typedef logic [15:0] word_t;

  localparam int N_INPUTS_DEF = 64;
  localparam int N_NODES_DEF  = 16;
  localparam int ACT_LAT_DEF  = 2;

endpackage

// File: rtl/ann_layer_ctrl_idx_counter.sv
// Mod-MOD index counter: synchronous clear beats enable, wraps to 0 after MOD-1.
module idx_counter #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(MOD - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/ann_layer_ctrl.sv
// Layer sequencer: walks every node through clear, MAC, activation drain and latch.
// Handshake: mem_stall=1 means the memory has no data this cycle; acc_en is the only output that sees it.
module ann_layer_ctrl
  import ann_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF,
  parameter int N_NODES  = N_NODES_DEF,
  parameter int ACT_LAT  = ACT_LAT_DEF,
  parameter int NW       = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          abort,
  input  logic          mem_stall,
  output logic [6:0]    cnt_val,
  output logic [NW-1:0] node_sel,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          act_latch,
  output logic          busy,
  output logic          done
);

  localparam int DRAIN_MOD = (ACT_LAT > 0) ? ACT_LAT : 1;

  state_t     state;
  state_t     state_nxt;
  logic       cnt_tc;
  logic       node_tc;
  logic       drain_tc;
  logic [2:0] drain_cnt_unused;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_MAC;
      ST_MAC:   if (acc_en && cnt_tc) state_nxt = (ACT_LAT == 0) ? ST_LATCH : ST_DRAIN;
      ST_DRAIN: if (drain_tc) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = node_tc ? ST_DONE : ST_CLEAR;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  assign acc_clr   = (state == ST_CLEAR);
  assign acc_en    = (state == ST_MAC) && !mem_stall;
  assign act_latch = (state == ST_LATCH);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Input index is cleared while latching so the next CLEAR (or DONE) already shows 0.
  idx_counter #(.MOD(N_INPUTS), .W(7)) u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (abort || (state == ST_LATCH)),
    .en    (acc_en && !cnt_tc),
    .count (cnt_val),
    .tc    (cnt_tc)
  );

  idx_counter #(.MOD(DRAIN_MOD), .W(3)) u_drain (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (state != ST_DRAIN),
    .en    (1'b1),
    .count (drain_cnt_unused),
    .tc    (drain_tc)
  );

  // The last node wraps back to 0, which is the value DONE and IDLE present.
  idx_counter #(.MOD(N_NODES), .W(NW)) u_node (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (abort),
    .en    (state == ST_LATCH),
    .count (node_sel),
    .tc    (node_tc)
  );

endmodule

// File: doc/ann_layer_ctrl.md
# ann_layer_ctrl

Sequencer that time-multiplexes one neural-network node datapath (64 × 16-bit coefficient/input MAC plus activation) across all nodes of a layer. On a start pulse it walks every node index: clears the accumulator, steps the input index through all inputs, waits out the activation latency, and strobes the node result into the layer result buffer. It sits between the network top-level control and the node datapath and coefficient memory.

## Interface
Parameters:
- N_INPUTS, 64, MAC steps per node; legal range 2..127
- N_NODES, 16, nodes per layer; legal range 1..256
- ACT_LAT, 2, cycles from last accumulate to valid activation output; legal range 0..7
- NW, $clog2(N_NODES) (minimum 1), node_sel width

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a layer pass; sampled only in IDLE
- abort  in  1  synchronous abort; valid in any state
- mem_stall  in  1  coefficient/input memory not ready this cycle
- cnt_val  out  7  input/coefficient index to the node datapath
- node_sel  out  NW  active node index; also the coefficient-bank select
- acc_clr  out  1  one-cycle accumulator clear
- acc_en  out  1  accumulate this cycle's product
- act_latch  out  1  capture the activation output for node_sel
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when a pass completes

## Operation
- States: IDLE, CLEAR, MAC, DRAIN, LATCH, DONE.
- IDLE: busy=0. start=1 moves to CLEAR. node_sel=0, cnt_val=0.
- CLEAR: acc_clr=1 and cnt_val=0 for 1 cycle, then MAC.
- MAC: acc_en = !mem_stall. cnt_val advances only when acc_en=1.
  - The accepted cycle with cnt_val=N_INPUTS-1 moves to DRAIN. If ACT_LAT=0, it moves to LATCH instead.
  - cnt_val holds N_INPUTS-1 until the next CLEAR.
- DRAIN: lasts exactly ACT_LAT cycles, using its own counter. acc_en=0. Then LATCH.
- LATCH: act_latch=1 for 1 cycle.
  - If node_sel=N_NODES-1, go to DONE.
  - Otherwise, node_sel increments and the state goes to CLEAR.
- DONE: done=1 for 1 cycle, then IDLE. node_sel and cnt_val return to 0.
- busy=1 in every state except IDLE.
- mem_stall is ignored outside MAC.
- start outside IDLE is ignored, including in DONE. No queuing.
- abort=1: next state is IDLE. All outputs take their reset values, and done is not pulsed. abort has priority over start and over every transition.
- Reset (n_rst=0): state IDLE, cnt_val=0, node_sel=0, acc_clr=acc_en=act_latch=busy=done=0.
- Reset asserted mid-pass has the same outcome as abort, but asynchronous.
- All outputs are registered or decoded from the registered state only. There is no combinational path from inputs to outputs, except acc_en from mem_stall.

## Timing
- Take the start-sampling edge as cycle 0.
- Per node, with no stalls: 1 (CLEAR) + N_INPUTS (MAC) + ACT_LAT (DRAIN) + 1 (LATCH) = N_INPUTS+ACT_LAT+2 cycles. That is 68 at the defaults.
- Node n's CLEAR is in cycle 1+n·68. Its LATCH is in cycle 68·(n+1).
- Defaults, no stalls: last LATCH in cycle 1088, done in cycle 1089, busy low from cycle 1090.
- Each stalled MAC cycle adds exactly 1 cycle.
- A new start is accepted at the earliest in cycle 1090.

## Structure
- Package ann_pkg holds:
  - the state enum typedef
  - the 16-bit word typedef shared with the node datapath
  - the default N_INPUTS / N_NODES constants
- Sub-module idx_counter: parameterised mod-N counter with clear, enable, count output and terminal-count flag.
  - It is instantiated three times: cnt_val, drain count, node_sel.
- The FSM and output decode stay in ann_layer_ctrl.

## Test plan
- Defaults, one start pulse, no stalls → acc_clr pulses at cycles 1, 69, …, 1021. acc_en is high for 64 consecutive cycles per node with cnt_val 0..63. act_latch is at 68·(n+1) with node_sel=n. done is at 1089.
- mem_stall high for 3 cycles while cnt_val=10 → acc_en low for those 3 cycles, cnt_val holds 10, done moves to 1092.
- abort in cycle 500 (mid-MAC, node 7) → cycle 501 is IDLE with all outputs 0 and no done. A start at 502 restarts from node_sel=0.
- start held high throughout a pass, including during DONE → exactly one pass. A new pass starts only from IDLE: done at 1089, next acc_clr at 1091.
- n_rst asserted in cycle 300 → all outputs 0 immediately. After release, start runs a full 1089-cycle pass.
- N_NODES=1, ACT_LAT=0, N_INPUTS=2 → CLEAR at cycle 1, MAC at 2–3, LATCH at 4, done at 5.
